// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants, text-grid geometry and the bundled output record.
package vga_timing_pkg;

    localparam int CW = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int CELL_W    = 8;
    localparam int CELL_H    = 16;

    typedef struct packed {
        logic [CW-1:0] hcount;
        logic [CW-1:0] vcount;
        logic          visible;
        logic          hsync;
        logic          vsync;
        logic [6:0]    char_col;
        logic [4:0]    char_row;
        logic [2:0]    glyph_x;
        logic [3:0]    glyph_y;
        logic          line_start;
        logic          frame_start;
    } vga_out_t;

    function automatic vga_out_t idle_out(logic sync_active);
        idle_out       = '0;
        idle_out.hsync = ~sync_active;
        idle_out.vsync = ~sync_active;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis -- wrapping position counter with terminal count, visible and sync-window decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   VISIBLE     = DEF_H_VISIBLE,
    parameter int   FRONT       = DEF_H_FRONT,
    parameter int   SYNC        = DEF_H_SYNC,
    parameter int   BACK        = DEF_H_BACK,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o,
    output logic          active_o,
    output logic          sync_o
);
    localparam logic [CW-1:0] LAST    = CW'(VISIBLE + FRONT + SYNC + BACK - 1);
    localparam logic [CW-1:0] VIS_END = CW'(VISIBLE);
    localparam logic [CW-1:0] SYNC_LO = CW'(VISIBLE + FRONT);
    localparam logic [CW-1:0] SYNC_HI = CW'(VISIBLE + FRONT + SYNC - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb count_d = !en_i ? count_q : tc_o ? '0 : count_q + CW'(1);

    always_ff @(posedge clk) count_q <= nrst ? count_d : '0;

    assign count_o  = count_q;
    assign tc_o     = count_q == LAST;
    assign active_o = count_q < VIS_END;
    assign sync_o   = (count_q >= SYNC_LO && count_q <= SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster and 80x30 text-cell timing from the dot clock.
// Define VGA_TIMING_REGOUT_EN to register every output (1 clk extra latency).
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic          clk,
    input  logic          nrst,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          visible,
    output logic          hsync,
    output logic          vsync,
    output logic [6:0]    char_col,
    output logic [4:0]    char_row,
    output logic [2:0]    glyph_x,
    output logic [3:0]    glyph_y,
    output logic          line_start,
    output logic          frame_start
);
    logic          rst_q;
    logic [CW-1:0] h, v;
    logic          h_tc, h_act, h_sync, v_tc, v_act, v_sync;
    logic          unused_v_tc;
    vga_out_t      live, dec, o;

    // Counters hold at (0,0) for the first released edge so (0,0) is shown for a full cycle.
    always_ff @(posedge clk) rst_q <= ~nrst;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_h (
        .clk(clk), .nrst(nrst), .en_i(~rst_q),
        .count_o(h), .tc_o(h_tc), .active_o(h_act), .sync_o(h_sync)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_v (
        .clk(clk), .nrst(nrst), .en_i(~rst_q & h_tc),
        .count_o(v), .tc_o(v_tc), .active_o(v_act), .sync_o(v_sync)
    );

    assign unused_v_tc = v_tc;

    assign live = vga_out_t'{
        hcount:      h,
        vcount:      v,
        visible:     h_act & v_act,
        hsync:       h_sync,
        vsync:       v_sync,
        char_col:    h[9:3],
        char_row:    v[8:4],
        glyph_x:     h[2:0],
        glyph_y:     v[3:0],
        line_start:  h == '0,
        frame_start: h == '0 && v == '0
    };

    assign dec = rst_q ? idle_out(SYNC_ACTIVE) : live;

`ifdef VGA_TIMING_REGOUT_EN
    vga_out_t out_q;
    always_ff @(posedge clk) out_q <= nrst ? dec : idle_out(SYNC_ACTIVE);
    assign o = out_q;
`else
    assign o = dec;
`endif

    assign hcount      = o.hcount;
    assign vcount      = o.vcount;
    assign visible     = o.visible;
    assign hsync       = o.hsync;
    assign vsync       = o.vsync;
    assign char_col    = o.char_col;
    assign char_row    = o.char_row;
    assign glyph_x     = o.glyph_x;
    assign glyph_y     = o.glyph_y;
    assign line_start  = o.line_start;
    assign frame_start = o.frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: three DUTs (full 640x480, narrow-line 525-line, tiny random-reset) checked every cycle against a position model.
module tb_vga_timing;

`ifdef VGA_TIMING_REGOUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    localparam int HV[3] = '{640, 8, 16};
    localparam int HF[3] = '{16, 1, 2};
    localparam int HS[3] = '{96, 1, 4};
    localparam int HB[3] = '{48, 1, 2};
    localparam int VV[3] = '{480, 480, 12};
    localparam int VF[3] = '{10, 10, 2};
    localparam int VS[3] = '{2, 2, 2};
    localparam int VB[3] = '{33, 33, 3};

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       vis;
        logic       hs;
        logic       vs;
        logic [6:0] cc;
        logic [4:0] cr;
        logic [2:0] gx;
        logic [3:0] gy;
        logic       ls;
        logic       fs;
    } o_t;

    typedef struct {
        int   k;
        int   h;
        int   v;
        logic vis;
        logic hs;
        logic ls;
    } vec_t;

    logic clk = 1'b0;
    logic nr[3];
    int   k[3];
    int   tests = 0, fails = 0, prints = 0;
    bit   started = 1'b0;

    logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic       a_vis, a_hs, a_vs, a_ls, a_fs, b_vis, b_hs, b_vs, b_ls, b_fs, c_vis, c_hs, c_vs, c_ls, c_fs;
    logic [6:0] a_cc, b_cc, c_cc;
    logic [4:0] a_cr, b_cr, c_cr;
    logic [2:0] a_gx, b_gx, c_gx;
    logic [3:0] a_gy, b_gy, c_gy;
    o_t oa, ob, oc;

    always #20 clk = ~clk;

    vga_timing u_a (
        .clk(clk), .nrst(nr[0]), .hcount(a_h), .vcount(a_v), .visible(a_vis), .hsync(a_hs), .vsync(a_vs),
        .char_col(a_cc), .char_row(a_cr), .glyph_x(a_gx), .glyph_y(a_gy), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing #(.H_VISIBLE(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(1)) u_b (
        .clk(clk), .nrst(nr[1]), .hcount(b_h), .vcount(b_v), .visible(b_vis), .hsync(b_hs), .vsync(b_vs),
        .char_col(b_cc), .char_row(b_cr), .glyph_x(b_gx), .glyph_y(b_gy), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing #(.H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
                 .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) u_c (
        .clk(clk), .nrst(nr[2]), .hcount(c_h), .vcount(c_v), .visible(c_vis), .hsync(c_hs), .vsync(c_vs),
        .char_col(c_cc), .char_row(c_cr), .glyph_x(c_gx), .glyph_y(c_gy), .line_start(c_ls), .frame_start(c_fs)
    );

    assign oa = {a_h, a_v, a_vis, a_hs, a_vs, a_cc, a_cr, a_gx, a_gy, a_ls, a_fs};
    assign ob = {b_h, b_v, b_vis, b_hs, b_vs, b_cc, b_cr, b_gx, b_gy, b_ls, b_fs};
    assign oc = {c_h, c_v, c_vis, c_hs, c_vs, c_cc, c_cr, c_gx, c_gy, c_ls, c_fs};

    // kk = released edges since the last reset edge; the raster position follows from it by plain arithmetic.
    function automatic o_t model(int i, int kk);
        o_t r;
        int ht, vt, p, h, v;
        r    = '0;
        r.hs = 1'b1;
        r.vs = 1'b1;
        if (kk < 1 + LAT) return r;
        ht   = HV[i] + HF[i] + HS[i] + HB[i];
        vt   = VV[i] + VF[i] + VS[i] + VB[i];
        p    = (kk - 1 - LAT) % (ht * vt);
        h    = p % ht;
        v    = p / ht;
        r.h  = 10'(h);
        r.v  = 10'(v);
        r.vis = h < HV[i] && v < VV[i];
        r.hs = !(h >= HV[i] + HF[i] && h < HV[i] + HF[i] + HS[i]);
        r.vs = !(v >= VV[i] + VF[i] && v < VV[i] + VF[i] + VS[i]);
        r.cc = 7'(h / 8);
        r.cr = 5'((v / 16) % 32);
        r.gx = 3'(h % 8);
        r.gy = 4'(v % 16);
        r.ls = h == 0;
        r.fs = p == 0;
        return r;
    endfunction

    task automatic cmp(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        o_t got, exp;
        @(posedge clk);
        for (int i = 0; i < 3; i++) k[i] = nr[i] ? k[i] + 1 : 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            got = i == 0 ? oa : i == 1 ? ob : oc;
            exp = model(i, k[i]);
            tests++;
            if (got !== exp) begin
                fails++;
                if (prints < 20) $display("FAIL cycle inst%0d k=%0d got=%h expected=%h", i, k[i], got, exp);
                prints++;
            end
        end
        nr[2] = started ? ($urandom_range(0, 249) != 0) : 1'b0;
    endtask

    initial begin
        vec_t vt[8];
        int   cnt, ls_cnt, last_fs, vis, vsl, nfs, n;
        bit   found;
        vt[0] = '{k: 1,   h: 0,   v: 0, vis: 1'b1, hs: 1'b1, ls: 1'b1};
        vt[1] = '{k: 640, h: 639, v: 0, vis: 1'b1, hs: 1'b1, ls: 1'b0};
        vt[2] = '{k: 641, h: 640, v: 0, vis: 1'b0, hs: 1'b1, ls: 1'b0};
        vt[3] = '{k: 657, h: 656, v: 0, vis: 1'b0, hs: 1'b0, ls: 1'b0};
        vt[4] = '{k: 752, h: 751, v: 0, vis: 1'b0, hs: 1'b0, ls: 1'b0};
        vt[5] = '{k: 753, h: 752, v: 0, vis: 1'b0, hs: 1'b1, ls: 1'b0};
        vt[6] = '{k: 800, h: 799, v: 0, vis: 1'b0, hs: 1'b1, ls: 1'b0};
        vt[7] = '{k: 801, h: 0,   v: 1, vis: 1'b1, hs: 1'b1, ls: 1'b1};
        nr[0] = 1'b0;
        nr[1] = 1'b0;
        nr[2] = 1'b0;
        for (int i = 0; i < 3; i++) k[i] = 0;
        repeat (10) step();
        cmp("rst_hcount", int'(a_h), 0);
        cmp("rst_visible", int'(a_vis), 0);
        cmp("rst_hsync", int'(a_hs), 1);
        cmp("rst_vsync", int'(a_vs), 1);
        cmp("rst_pulses", int'({a_ls, a_fs}), 0);
        nr[0]   = 1'b1;
        nr[1]   = 1'b1;
        started = 1'b1;
        step();
        cmp("first_frame_start", int'(a_fs), LAT ? 0 : 1);
        for (int j = 0; j < 8; j++) begin
            while (k[0] < vt[j].k + LAT) step();
            cmp($sformatf("vec%0d_h", j), int'(a_h), vt[j].h);
            cmp($sformatf("vec%0d_v", j), int'(a_v), vt[j].v);
            cmp($sformatf("vec%0d_vis", j), int'(a_vis), int'(vt[j].vis));
            cmp($sformatf("vec%0d_hs", j), int'(a_hs), int'(vt[j].hs));
            cmp($sformatf("vec%0d_ls", j), int'(a_ls), int'(vt[j].ls));
        end
        cnt    = 0;
        ls_cnt = 0;
        for (int j = 0; j < 800; j++) begin
            step();
            if (!a_hs) cnt++;
            if (a_ls) ls_cnt++;
            if (a_h == 10'd639) begin
                cmp("char_col_639", int'(a_cc), 79);
                cmp("glyph_x_639", int'(a_gx), 7);
            end
        end
        cmp("hsync_low_cycles", cnt, 96);
        cmp("line_starts_per_line", ls_cnt, 1);
        last_fs = -1;
        vis     = 0;
        vsl     = 0;
        nfs     = 0;
        for (n = 0; n < 3 * 5775 + 10; n++) begin
            step();
            if (b_fs) begin
                if (last_fs >= 0) begin
                    cmp("frame_period", n - last_fs, 5775);
                    cmp("visible_per_frame", vis, 3840);
                end
                last_fs = n;
                vis     = 0;
                nfs++;
            end
            if (b_vis) vis++;
            if (!b_vs) begin
                if (vsl == 0) begin
                    cmp("vsync_start_v", int'(b_v), 490);
                    cmp("vsync_start_h", int'(b_h), 0);
                end
                vsl++;
            end else if (vsl != 0) begin
                cmp("vsync_low_cycles", vsl, 22);
                vsl = 0;
            end
            if (b_v == 10'd479 && b_h == 10'd0) begin
                cmp("char_row_479", int'(b_cr), 29);
                cmp("glyph_y_479", int'(b_gy), 15);
            end
        end
        cmp("frames_seen", int'(nfs >= 3), 1);
        found = 1'b0;
        for (int j = 0; j < 6000 && !found; j++) begin
            step();
            found = b_v == 10'd300 && b_h == 10'd5;
        end
        cmp("reach_v300", int'(found), 1);
        nr[1] = 1'b0;
        step();
        cmp("midrst_hcount", int'(b_h), 0);
        cmp("midrst_vcount", int'(b_v), 0);
        cmp("midrst_visible", int'(b_vis), 0);
        cmp("midrst_syncs", int'({b_hs, b_vs}), 3);
        cmp("midrst_pulses", int'({b_ls, b_fs}), 0);
        nr[1] = 1'b1;
        step();
        repeat (LAT) step();
        cmp("restart_frame_start", int'(b_fs), 1);
        cmp("restart_visible", int'(b_vis), 1);
        cmp("restart_hcount", int'(b_h), 0);
        repeat (2000) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480 @ 60 Hz VGA raster timing from the 25.175 MHz dot clock distributed on the global buffer. Produces hsync/vsync, a visible-area flag, pixel coordinates, and text-mode character/glyph coordinates for an 80x30 grid of 8x16 cells. It sits between the clock buffer and the pixel/attribute pipeline and the output pins, replacing the free-running test counter on hsync/vsync.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (dots)
- H_SYNC, 96, horizontal sync width (dots)
- H_BACK, 48, horizontal back porch (dots)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, asserted level of hsync and vsync (both negative for 640x480)

- clk  in  1  dot clock, 25.175 MHz
- nrst  in  1  reset: synchronous, active-low
- hcount  out  10  dot index within line, 0..799
- vcount  out  10  line index within frame, 0..524
- visible  out  1  high when hcount<640 and vcount<480
- hsync  out  1  horizontal sync, SYNC_ACTIVE when asserted
- vsync  out  1  vertical sync, SYNC_ACTIVE when asserted
- char_col  out  7  hcount[9:3], valid 0..79 when visible
- char_row  out  5  vcount[8:4], valid 0..29 when visible
- glyph_x  out  3  hcount[2:0], bit column in glyph
- glyph_y  out  4  vcount[3:0], glyph scanline
- line_start  out  1  one-cycle pulse when hcount==0
- frame_start  out  1  one-cycle pulse when hcount==0 and vcount==0

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525); all counters 10 bits unsigned.
- hcount increments every clk; at H_TOTAL-1 wraps to 0 and vcount increments; vcount at V_TOTAL-1 with hcount at H_TOTAL-1 wraps to 0.
- hsync asserted for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
- vsync asserted for vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491], full lines (changes at hcount==0).
- char/glyph outputs are bit slices; no divider. Outside visible area values are don't-care but still equal the slices.
- While nrst=0 (sampled at posedge): hcount=vcount=0, visible=0, hsync=vsync=~SYNC_ACTIVE, line_start=frame_start=0.
- Reset mid-frame: next posedge with nrst=0 forces all of the above; no partial-line completion.

## Timing
- Unregistered-output build: outputs are combinational decode of counter registers; latency 0 from counter state.
- First posedge with nrst=1 after reset: outputs reflect (0,0): visible=1, line_start=1, frame_start=1, syncs inactive.
- Frame period exactly 420000 clk cycles; line period 800.
- Simultaneous wrap (h 799, v 524) takes priority over vcount increment: next state (0,0).

## Configuration
- VGA_TIMING_REGOUT_EN: when defined, every output (hcount..frame_start) passes through one register stage; all outputs delayed exactly 1 clk relative to counters, mutually aligned, glitch-free at pins; reset values as above, applied to the output registers too. First post-reset cycle then shows reset values; (0,0) values appear one cycle later.
- Undefined: combinational decode, 0 latency.

## Structure
- Package vga_timing_pkg: default 640x480 porch/sync constants, H_TOTAL/V_TOTAL, counter width, text grid constants (80 cols, 30 rows, 8x16 cell).
- Sub-module vga_axis_counter: parameterised wrap counter with enable, terminal-count output, and sync-window decode; instantiated once for horizontal (enable=1) and once for vertical (enable=horizontal terminal count).

## Test plan
- Hold nrst=0 10 cycles -> hcount=0, vcount=0, visible=0, hsync=vsync=1, pulses 0.
- Release nrst, run 1 line -> hsync low exactly on hcount 656..751 (96 cycles), line_start every 800 cycles.
- Run 2 full frames -> frame_start spacing 420000 cycles; vsync low for 1600 consecutive cycles starting vcount=490, hcount=0.
- Check visible count per frame = 307200; char_col=79, glyph_x=7 at hcount=639; char_row=29, glyph_y=15 at vcount=479.
- Assert nrst=0 at vcount=300, hcount=400 for 1 cycle -> next cycle all outputs at reset values; restart from (0,0) with frame_start.
- Build with VGA_TIMING_REGOUT_EN -> every output equals unregistered-build output delayed 1 cycle.
